// File: rtl/lsu_hs_if.sv
// -----------------------------------------------------------------------------
// lsu_hs_if: bundle of the core-side request/response handshake and the
// data-memory req/gnt/rvalid port seen by the load/store unit.
//
// Signals (directions are from the LSU's point of view, modport slave):
//   req_valid_i / req_ready_o   core request handshake
//   rw_ctrl_i [3:0]             [3]=store, [2:0]=b/h/w/bu/hu
//   addr_i [ADDR_W-1:0]         byte address
//   wdata_i [31:0]              store data, low bits valid
//   rsp_valid_o / rsp_ready_i   core response handshake
//   rsp_data_o [31:0]           load result
//   rsp_err_o [1:0]             00 ok, 01 misaligned, 10 timeout, 11 illegal
//   mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o   memory request
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i                     memory response
//
// modport slave  : the LSU
// modport master : the environment (core + memory) driving the LSU
// -----------------------------------------------------------------------------
interface lsu_hs_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [3:0]        rw_ctrl_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_data_o;
  logic [1:0]        rsp_err_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  req_valid_i, rw_ctrl_i, addr_i, wdata_i, rsp_ready_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, rw_ctrl_i, addr_i, wdata_i, rsp_ready_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_hs.sv
// -----------------------------------------------------------------------------
// lsu_hs: handshaked load/store unit between the MEM stage and a
// req/gnt/rvalid data-memory port. One transaction outstanding.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  lsu_hs_if.slave (core request/response + memory port)
//
// Flow: IDLE accepts and classifies a request. Illegal/misaligned requests
// go straight to RESP without touching memory; legal ones issue a registered
// memory request (REQ), wait for the read data / write ack (WAIT), then hold
// the response (RESP) until the core takes it. A cycle counter spanning
// REQ+WAIT turns a stalled memory into a bus-timeout response.
// -----------------------------------------------------------------------------
module lsu_hs #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input logic    clk,
  input logic    rst,
  lsu_hs_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [1:0]        off_q, off_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  // Request classification, only meaningful while accepting in IDLE.
  logic       illegal, misaligned;
  logic [2:0] sz;
  logic [1:0] a_lo;
  assign sz   = bus.rw_ctrl_i[2:0];
  assign a_lo = bus.addr_i[1:0];
  assign illegal    = bus.rw_ctrl_i[3] ? (sz > 3'b010) : (sz > 3'b100);
  assign misaligned = ((sz == 3'b001 || sz == 3'b100) && a_lo[0]) ||
                      ((sz == 3'b010) && (a_lo != 2'b00));

  // Load result: shift the addressed lane down, then extend by size.
  logic [31:0] lane, load_data;
  always_comb begin
    lane = bus.mem_rdata_i >> {off_q, 3'b000};
    case (ctrl_q[2:0])
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b011:  load_data = {24'h0, lane[7:0]};
      3'b100:  load_data = {16'h0, lane[15:0]};
      default: load_data = lane;
    endcase
    if (ctrl_q[3]) load_data = 32'h0;
  end

  // NOTE: every always_comb output gets a default first so no path
  // through the case leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          ctrl_d = bus.rw_ctrl_i;
          off_d  = a_lo;
          cnt_d  = 8'h0;
          if (illegal || misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'h0;
            rsp_err_d   = illegal ? ERR_ILL : ERR_MIS;
          end else begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_we_d   = bus.rw_ctrl_i[3];
            mem_addr_d = {bus.addr_i[ADDR_W-1:2], 2'b00};
            case (sz)
              3'b000, 3'b011: begin
                mem_be_d    = 4'b0001 << a_lo;
                mem_wdata_d = {4{bus.wdata_i[7:0]}};
              end
              3'b001, 3'b100: begin
                mem_be_d    = 4'b0011 << a_lo;
                mem_wdata_d = {2{bus.wdata_i[15:0]}};
              end
              default: begin
                mem_be_d    = 4'b1111;
                mem_wdata_d = bus.wdata_i;
              end
            endcase
          end
        end
      end

      REQ: begin
        cnt_d = cnt_q + 8'h1;
        if (bus.mem_gnt_i) begin
          mem_req_d = 1'b0;
          if (bus.mem_rvalid_i) begin
            // Zero-latency memory: response in the grant cycle.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = load_data;
            rsp_err_d   = ERR_OK;
          end else begin
            state_d = WAIT;
          end
        end else if (cnt_q >= CNT_LAST) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'h0;
          rsp_err_d   = ERR_TO;
        end
      end

      WAIT: begin
        cnt_d = cnt_q + 8'h1;
        if (bus.mem_rvalid_i) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = load_data;
          rsp_err_d   = ERR_OK;
        end else if (cnt_q >= CNT_LAST) begin
          // >= also covers a grant that landed exactly on the last count.
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'h0;
          rsp_err_d   = ERR_TO;
        end
      end

      RESP: begin
        // Stray rvalid after a timeout is ignored simply by not looking at it.
        if (bus.rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = 32'h0;
          rsp_err_d   = ERR_OK;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order; the reset here is
  // synchronous, so it lives inside the clocked branch rather than the list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ctrl_q      <= 4'h0;
      off_q       <= 2'b00;
      cnt_q       <= 8'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= ERR_OK;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_be_o    = mem_be_q;
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/lsu_hs.md
Name: lsu_hs

Overview:
- Parametrised, handshaked successor to the combinational load/store unit.
- Sits between the core's MEM stage and a req/gnt/rvalid data-memory port.
- Accepts one load/store per request, generates byte enables and lane-aligned store data, and extracts and extends load data by byte offset.
- Detects misaligned and illegal accesses and times out a stalled memory.
- One transaction outstanding; multi-cycle FSM with backpressure on both sides.

Parameters:
- ADDR_W, 12, width of the address to data memory (byte address).
- TIMEOUT, 16, cycles allowed in REQ+WAIT before a bus-error response; range 2..255.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  unit can accept a request (high only in IDLE).
- rw_ctrl_i  in  4  [3]=1 store / 0 load; [2:0] = 000 b, 001 h, 010 w, 011 bu, 100 hu.
- addr_i  in  ADDR_W  byte address from ALU.
- wdata_i  in  32  store data from regfile (low bits valid).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  core accepts response.
- rsp_data_o  out  32  load result (0 for stores and errors).
- rsp_err_o  out  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal type.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  lane-shifted store data.
- mem_gnt_i  in  1  memory accepted request.
- mem_rvalid_i  in  1  read data valid / write ack.
- mem_rdata_i  in  32  full word read.

Behaviour:
- Reset: state=IDLE. req_ready_o=1; rsp_valid_o=0; rsp_data_o=0; rsp_err_o=00; mem_req_o=0; mem_we_o=0; mem_addr_o=0; mem_be_o=0; mem_wdata_o=0; timeout counter=0.
- Reset mid-transaction abandons the transaction: no response is issued, and a late mem_rvalid_i in IDLE is ignored.
- IDLE: on req_valid_i&&req_ready_o, latch ctrl, addr and wdata, then classify.
  - Illegal: store with [2:0]>010, or load with [2:0]>100 -> RESP, err=11.
  - Misaligned: h/hu with addr[0]=1, or w with addr[1:0]!=0 -> RESP, err=01.
  - Error paths make no memory access.
  - Otherwise -> REQ, with mem outputs registered (valid the cycle after acceptance).
- Byte enables:
  - b/bu: 0001<<addr[1:0].
  - h/hu: 0011<<addr[1:0].
  - w: 1111.
- Store data: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- REQ: mem_req_o held with stable addr/be/we/wdata until mem_gnt_i. On gnt, drop mem_req_o next cycle and go to WAIT. If mem_rvalid_i arrives in the same cycle as gnt, go directly to RESP.
- WAIT: on mem_rvalid_i -> RESP, err=00.
  - Loads: select lane by the latched addr[1:0]. Sign-extend b/h; zero-extend bu/hu.
  - Stores: rsp_data_o=0.
- Timeout:
  - Counter clears on acceptance and increments every cycle in REQ or WAIT.
  - When counter==TIMEOUT-1 with no gnt/rvalid that cycle -> RESP, err=10, mem_req_o deasserted.
  - A later stray rvalid is ignored.
- RESP: rsp_valid_o=1 with data/err stable until rsp_ready_i. Then IDLE; rsp_valid_o drops the next cycle.
- Back-to-back: the next request cannot be accepted in the handshake cycle; req_ready_o rises the cycle after.
- Minimum load latency, with gnt in the first REQ cycle and rvalid one cycle later: accept cycle 0, mem_req_o cycles 1, rvalid cycle 2, rsp_valid_o cycle 3.
- Error-path latency: rsp_valid_o in cycle 1.
- All outputs are registered; no combinational path from mem inputs to rsp outputs.

Test Plan:
- Reset:
  - Stimulus: assert rst for 2 cycles while in WAIT.
  - Response: next cycle all outputs at reset values and req_ready_o=1; a following rvalid produces no response.
- lb sign-extension:
  - Stimulus: addr=0x0A3, mem_rdata=0x80FF_7F01, gnt immediate, rvalid +1.
  - Response: mem_addr=0x0A0, be=1000, rsp_data=0xFFFF_FF80, err=00, rsp_valid in cycle 3.
- lhu:
  - Stimulus: addr=0x006, same rdata.
  - Response: be=1100, rsp_data=0x0000_80FF.
- sb:
  - Stimulus: addr=0x011, wdata=0x1234_56AB.
  - Response: mem_we=1, be=0010, mem_wdata=0xABAB_ABAB, rsp_data=0, err=00.
- Error paths:
  - sw at addr=0x002 -> err=01, rsp_valid cycle 1, mem_req never asserted.
  - store ctrl=1011 -> err=11.
- Timeout and backpressure:
  - Stimulus: TIMEOUT=16, gnt never asserted; hold rsp_ready_i=0 for 5 cycles once the response is valid.
  - Response: err=10 after 16 REQ cycles; response held stable for the 5 stalled cycles, then IDLE.
